// File: rtl/alu_shift_sequencer_pkg.sv
// Shared op-code and state encodings for the ALU shift path.
// The ALU decoder and the testbench import the same definitions.
package alu_shift_sequencer_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/alu_shift_1bit_stage.sv
// Single-position shift stage; the fill bit depends on the selected op.
module alu_shift_1bit_stage
  import alu_shift_sequencer_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [1:0]   op,
  output logic [N-1:0] Z
);

  // One-position shift with op-selected fill
  always_comb begin
    Z = A;
    case (op)
      OP_SLL:  Z = {A[N-2:0], 1'b0};
      OP_SRL:  Z = {1'b0, A[N-1:1]};
      OP_SRA:  Z = {A[N-1], A[N-1:1]};
      OP_ROR:  Z = {A[0], A[N-1:1]};
      default: Z = A;
    endcase
  end

endmodule

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle shift sequencer: reuses one single-position stage for up to
// N-1 cycles and holds the result until the consumer acks it.
//
//   state   | meaning
//   --------+---------------------------------------------
//   S_IDLE  | ready for a new operation
//   S_SHIFT | shifting one position per cycle, counting down
//   S_DONE  | result on z, waiting for ack
module alu_shift_sequencer
  import alu_shift_sequencer_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] shamt,
  output logic          ready,
  output logic          busy,
  output logic          valid,
  output logic [N-1:0]  z,
  input  logic          ack
);

  state_t        state, state_n;
  logic [N-1:0]  work, work_n;
  logic [SW-1:0] cnt, cnt_n;
  logic [1:0]    op_q, op_n;
  logic [N-1:0]  stage_z;

  alu_shift_1bit_stage #(.N(N)) u_stage (
    .A  (work),
    .op (op_q),
    .Z  (stage_z)
  );

  // State, work register, counter and latched op; synchronous reset
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= S_IDLE;
      work  <= '0;
      cnt   <= '0;
      op_q  <= OP_SLL;
    end else begin
      state <= state_n;
      work  <= work_n;
      cnt   <= cnt_n;
      op_q  <= op_n;
    end
  end

  // Next-state, datapath next values and one-hot status outputs
  always_comb begin
    state_n = state;
    work_n  = work;
    cnt_n   = cnt;
    op_n    = op_q;
    ready   = 1'b0;
    busy    = 1'b0;
    valid   = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          work_n  = a;
          op_n    = op;
          cnt_n   = shamt;
          state_n = (shamt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy   = 1'b1;
        work_n = stage_z;
        cnt_n  = cnt - SW'(1);
        if (cnt == SW'(1)) state_n = S_DONE;
      end
      S_DONE: begin
        valid = 1'b1;
        if (ack) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign z = work;

endmodule
